pc_gen_unit: RTL and testbench

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_gen_unit_if.sv | 12 +
 rtl/pc_gen_unit_next_sel.sv | 50 +++++
 rtl/pc_gen_unit.sv | 106 ++++++++++
 tb/tb_pc_gen_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch PC generator: FSM states,
// reset fetch address and sequential PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_INC           = 4;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch request handshake between the PC generator (master) and the
// instruction fetch stage (slave).
interface pc_gen_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;

  modport master (output pc, output pc_valid, input pc_ready);
  modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_gen_unit_next_sel.sv
// Next-PC priority mux (trap > mret > redirect > sequential) with the
// target alignment check that diverts misaligned targets to the trap vector.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            active_i,
  input  logic            adv_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            event_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] vec_base;

  assign vec_base = mtvec_i & ~XLEN'(3);

  always_comb begin
    event_o    = 1'b0;
    misalign_o = 1'b0;
    target_o   = pc_i;
    pc_d_o     = pc_i;
    if (active_i && trap_i) begin
      event_o = 1'b1;
      pc_d_o  = vec_base;
    end else if (active_i && (mret_i || redirect_i)) begin
      // mret wins over a same-cycle redirect; the redirect is simply lost.
      event_o  = 1'b1;
      target_o = mret_i ? mepc_i : redirect_pc_i;
      if (is_misaligned(target_o[1:0])) begin
        misalign_o = 1'b1;
        pc_d_o     = vec_base;
      end else begin
        pc_d_o = target_o;
      end
    end else if (adv_i) begin
      pc_d_o = pc_i + XLEN'(PC_INC);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN/HALT control, PC register, flush and
// misalignment reporting, and a count of accepted fetch handshakes.
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_gen_unit_if.master     fetch_if,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic              halt_i,
  input  logic              resume_i,
  output logic              flush_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_pc_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  pc_state_e        state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  misalign_pc_q;
  logic [XLEN-1:0]  sel_target;
  logic             pc_valid_q;
  logic             flush_q;
  logic             misalign_q;
  logic             sel_event;
  logic             sel_misalign;
  logic             fire;
  logic [CNT_W-1:0] cnt_q;

  // pc_valid_q is only ever set in RUN, so fire implies RUN.
  assign fire = pc_valid_q & fetch_if.pc_ready;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_next_sel (
    .active_i      (state_q != ST_BOOT),
    .adv_i         (fire),
    .pc_i          (pc_q),
    .trap_i        (trap_i),
    .mret_i        (mret_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mtvec_i       (mtvec_i),
    .mepc_i        (mepc_i),
    .event_o       (sel_event),
    .pc_d_o        (pc_d),
    .misalign_o    (sel_misalign),
    .target_o      (sel_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (fire) cnt_q <= cnt_q + CNT_W'(1);
      if (sel_event || fire) pc_q <= pc_d;
      if (sel_event) flush_q <= 1'b1;
      if (sel_misalign) begin
        misalign_q    <= 1'b1;
        misalign_pc_q <= sel_target;
      end
      case (state_q)
        ST_RUN, ST_HALT: begin
          // halt_i dominates resume_i when both are asserted.
          if (halt_i) begin
            state_q    <= ST_HALT;
            pc_valid_q <= 1'b0;
          end else if (state_q == ST_HALT && resume_i) begin
            state_q    <= ST_RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign fetch_if.pc       = pc_q;
  assign fetch_if.pc_valid = pc_valid_q;
  assign flush_o           = flush_q;
  assign misalign_o        = misalign_q;
  assign misalign_pc_o     = misalign_pc_q;
  assign fetch_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_gen_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, trap, mret, halt, resume;
  logic [31:0] redirect_pc, mtvec, mepc;
  logic        flush, misalign;
  logic [31:0] misalign_pc, fetch_cnt;

  pc_gen_unit_if #(.XLEN(32)) fif ();

  pc_gen_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .CNT_W    (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_if      (fif),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .trap_i        (trap),
    .mtvec_i       (mtvec),
    .mret_i        (mret),
    .mepc_i        (mepc),
    .halt_i        (halt),
    .resume_i      (resume),
    .flush_o       (flush),
    .misalign_o    (misalign),
    .misalign_pc_o (misalign_pc),
    .fetch_cnt_o   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int          m_mode;
  logic [31:0] m_pc, m_mis_pc, m_cnt;
  bit          m_valid, m_flush, m_mis;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_BOOT;
    m_pc     = RST_PC;
    m_valid  = 1'b0;
    m_flush  = 1'b0;
    m_mis    = 1'b0;
    m_mis_pc = '0;
    m_cnt    = '0;
  endtask

  // Apply one rising edge's worth of the rules, using inputs held stable across it.
  task automatic model_update();
    logic [31:0] nxt;
    bit          accepted;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else begin
      accepted = m_valid && fif.pc_ready;
      if (accepted) m_cnt = m_cnt + 1;
      if (trap)            nxt = {mtvec[31:2], 2'b00};
      else if (mret)       nxt = mepc;
      else if (redirect)   nxt = redirect_pc;
      else if (accepted)   nxt = m_pc + 32'd4;
      else                 nxt = m_pc;
      if (!trap && (mret || redirect) && nxt[1:0] != 2'b00) begin
        m_mis    = 1'b1;
        m_mis_pc = nxt;
        nxt      = {mtvec[31:2], 2'b00};
      end
      m_flush = trap || mret || redirect;
      m_pc    = nxt;
      if (halt)                         m_mode = M_HALT;
      else if (m_mode == M_HALT && resume) m_mode = M_RUN;
    end
    m_valid = (m_mode == M_RUN);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_ev();
    redirect = 1'b0; trap = 1'b0; mret = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(posedge clk) begin
    #1;
    chk("pc_o", fif.pc, m_pc);
    chk("pc_valid_o", fif.pc_valid, m_valid);
    chk("flush_o", flush, m_flush);
    chk("misalign_o", misalign, m_mis);
    chk("misalign_pc_o", misalign_pc, m_mis_pc);
    chk("fetch_cnt_o", fetch_cnt, m_cnt);
  end

  initial begin
    clear_ev();
    fif.pc_ready = 1'b0;
    redirect_pc  = '0;
    mtvec        = '0;
    mepc         = '0;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) step();
    chk("reset_pc", fif.pc, 32'h8000_0000);
    chk("reset_valid", fif.pc_valid, 1'b0);
    chk("reset_cnt", fetch_cnt, 32'd0);
    chk("reset_flush", flush, 1'b0);

    // Release: first edge only leaves BOOT
    rst_n = 1'b1;
    fif.pc_ready = 1'b1;
    step();
    chk("boot_valid", fif.pc_valid, 1'b1);
    chk("boot_pc", fif.pc, 32'h8000_0000);
    chk("boot_cnt", fetch_cnt, 32'd0);
    step(); step();
    chk("seq_pc2", fif.pc, 32'h8000_0008);
    chk("seq_cnt2", fetch_cnt, 32'd2);

    fif.pc_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_pc", fif.pc, 32'h8000_0008);
      chk("stall_valid", fif.pc_valid, 1'b1);
      chk("stall_cnt", fetch_cnt, 32'd2);
    end
    fif.pc_ready = 1'b1;
    step(); step();
    chk("seq_pc4", fif.pc, 32'h8000_0010);
    chk("seq_cnt4", fetch_cnt, 32'd4);

    // Redirect while not ready
    fif.pc_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step(); clear_ev();
    chk("redir_flush", flush, 1'b1);
    chk("redir_pc", fif.pc, 32'h8000_0100);
    step();
    chk("redir_flush_end", flush, 1'b0);

    // Trap beats redirect; mtvec low bits cleared
    trap = 1'b1; mtvec = 32'h8000_0203;
    redirect = 1'b1; redirect_pc = 32'h8000_0300;
    step(); clear_ev();
    chk("trap_pc", fif.pc, 32'h8000_0200);
    chk("trap_flush", flush, 1'b1);
    chk("trap_nomis", misalign, 1'b0);
    mret = 1'b1; mepc = 32'h8000_0040;
    step(); clear_ev();
    chk("mret_pc", fif.pc, 32'h8000_0040);

    // Misaligned redirect target goes to the vector
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step(); clear_ev();
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_addr", misalign_pc, 32'h8000_0102);
    chk("mis_pc", fif.pc, 32'h8000_0200);
    step();
    chk("mis_end", misalign, 1'b0);
    chk("mis_addr_hold", misalign_pc, 32'h8000_0102);

    // Halt / resume
    halt = 1'b1;
    step(); halt = 1'b0;
    chk("halt_valid", fif.pc_valid, 1'b0);
    chk("halt_pc", fif.pc, 32'h8000_0200);
    fif.pc_ready = 1'b1;
    step();
    chk("halt_hold_pc", fif.pc, 32'h8000_0200);
    chk("halt_hold_cnt", fetch_cnt, 32'd4);
    halt = 1'b1; resume = 1'b1;
    step(); clear_ev();
    chk("halt_resume_both", fif.pc_valid, 1'b0);
    resume = 1'b1;
    step(); clear_ev();
    chk("resume_valid", fif.pc_valid, 1'b1);
    chk("resume_pc", fif.pc, 32'h8000_0200);

    // Wrap of sequential PC
    fif.pc_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); clear_ev();
    fif.pc_ready = 1'b1;
    step();
    chk("wrap_pc", fif.pc, 32'h0000_0000);
    chk("wrap_cnt", fetch_cnt, 32'd5);

    // Reset in the middle of a handshake
    step();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_pc", fif.pc, 32'h8000_0000);
    chk("midrst_cnt", fetch_cnt, 32'd0);
    chk("midrst_valid", fif.pc_valid, 1'b0);
    step();
    rst_n = 1'b1;

    // Randomized traffic
    repeat (3000) begin
      logic [31:0] r;
      fif.pc_ready = ($urandom_range(0, 2) != 0);
      trap     = ($urandom_range(0, 31) == 0);
      mret     = ($urandom_range(0, 23) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      halt     = ($urandom_range(0, 23) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      mepc  = r;
      mtvec = $urandom;
      if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    clear_ev();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
